sad_min_reduce: RTL and testbench
=================================

Name: sad_min_reduce

Overview:
- EX7-side consumer of the custom SAD instruction's eight candidate outputs (sOut1..sOut8) and the window's base coordinates (outx, outy).
- A 3-stage pipelined comparator tree reduces each issued SAD group to its minimum plus that minimum's coordinates.
- A running-best register then tracks the global minimum across successive SAD instructions until software clears it.
- Outputs feed the writeback mux, so a later SAD-result read returns the best match and its x/y.

Parameters:
- DATA_W, 32, width of each SAD candidate and of best/result SAD.
- COORD_W, 32, width of x/y coordinates.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- sad_EX7  input  1  SAD group valid this cycle.
- clear_best  input  1  re-arm the running best (one-cycle pulse).
- sOut1_EX7..sOut8_EX7  input  DATA_W each  candidates 1..8.
- outx_EX7  input  COORD_W  base x of the candidate group.
- outy_EX7  input  COORD_W  row y of the candidate group.
- result_valid  output  1  one-cycle pulse: the group minimum is on result_*.
- result_sad  output  DATA_W  group minimum SAD.
- result_x  output  COORD_W  x of the group minimum.
- result_y  output  COORD_W  y of the group minimum.
- best_valid  output  1  running best holds at least one group since clear/reset.
- best_sad  output  DATA_W  running minimum SAD.
- best_x  output  COORD_W  x of the running minimum.
- best_y  output  COORD_W  y of the running minimum.
- busy  output  1  any pipeline stage holds a valid group.

Behaviour:
- Reset (sync, high), at the clock edge:
  - All stage valids = 0; result_valid = 0; result_sad/x/y = 0.
  - best_valid = 0; best_sad = all-ones (2^DATA_W-1); best_x = best_y = 0; busy = 0.
  - Reset asserted mid-operation discards all in-flight groups; no result_valid pulse follows.
- Candidate k (1..8) maps to coordinate x = outx_EX7 + (k-1) modulo 2^COORD_W (wraps), y = outy_EX7.
- Stage 1 (edge after sad_EX7 = 1):
  - Registers 4 pair-minima (1v2, 3v4, 5v6, 7v8) with 3-bit index and captured outx/outy.
  - Compare is unsigned.
  - Tie: lower index wins.
- Stage 2: registers 2 minima of the stage-1 pairs, same tie rule.
- Stage 3:
  - Registers the final minimum; result_valid = 1 for exactly one cycle.
  - result_sad = minimum; result_x = base x + index; result_y = base y.
- Latency: sad_EX7 high in cycle N gives result_valid high in cycle N+3.
- Throughput: one group per cycle. Back-to-back sad_EX7 produces back-to-back result_valid with no bubbles. No stall or backpressure.
- Idle stage: stages hold data when their valid = 0; only the valid bit advances.
- busy = OR of the three stage valids.
- Running best update on the edge after result_valid is high (visible at cycle N+4):
  - If best_valid = 0, or result_sad < best_sad (strictly less, unsigned): load result_sad/x/y into best_*, set best_valid = 1.
  - Equal SAD: the earlier group is kept.
- clear_best at an edge:
  - With no concurrent update: best_valid = 0, best_sad = all-ones, best_x = best_y = 0.
  - Concurrent with a pending update: clear applies first, then the update loads. End state is best = that result, best_valid = 1.
  - In-flight groups are unaffected by clear_best.
- sad_EX7 = 0: sOut/outx/outy values are ignored.
- Candidate value all-ones is legal. It loads into best when best_valid = 0; best_valid distinguishes this from the cleared state.

Test Plan:
- Reset, then sOut1..8 = {50,40,30,20,10,60,70,80}, outx = 4, outy = 9, sad_EX7 pulse in cycle 0 -> result_valid in cycle 3 only, result_sad = 10, result_x = 8, result_y = 9; cycle 4: best_valid = 1, best_sad = 10, best_x = 8, best_y = 9.
- Tie: all eight candidates = 7, outx = 0, outy = 0 -> result_sad = 7, result_x = 0. Then a second group, all = 7, outx = 100 -> best stays (7, 0, 0).
- Back-to-back: groups in cycles 0, 1, 2 with minima 30 @ x = 2, 15 @ x = 11, 15 @ x = 21 -> result_valid in cycles 3, 4, 5; best after cycle 6 = (15, 11, y); busy high in cycles 1-5 and low in cycle 6.
- Wrap: outx = 0xFFFFFFFE, minimum at candidate 4 -> result_x = 0x00000001.
- clear_best coincident with the update edge for group min 99 (old best 5) -> best = 99, best_valid = 1. clear_best alone later -> best_valid = 0, best_sad = 0xFFFFFFFF.
- Reset asserted in cycle 1 after a group issued in cycle 0 -> no result_valid in cycle 3; busy = 0 and best_valid = 0 from cycle 2.

Source files
------------

// File: rtl/sad_min_reduce_if.sv
// Bundles the SAD candidate group coming out of EX7 and the reduced results
// going back to the writeback mux.
interface sad_min_reduce_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COORD_W = 32
);
  logic               sad_EX7;
  logic               clear_best;
  logic [DATA_W-1:0]  sOut1_EX7, sOut2_EX7, sOut3_EX7, sOut4_EX7;
  logic [DATA_W-1:0]  sOut5_EX7, sOut6_EX7, sOut7_EX7, sOut8_EX7;
  logic [COORD_W-1:0] outx_EX7;
  logic [COORD_W-1:0] outy_EX7;

  logic               result_valid;
  logic [DATA_W-1:0]  result_sad;
  logic [COORD_W-1:0] result_x;
  logic [COORD_W-1:0] result_y;
  logic               best_valid;
  logic [DATA_W-1:0]  best_sad;
  logic [COORD_W-1:0] best_x;
  logic [COORD_W-1:0] best_y;
  logic               busy;

  modport master (
    output sad_EX7, clear_best,
    output sOut1_EX7, sOut2_EX7, sOut3_EX7, sOut4_EX7,
    output sOut5_EX7, sOut6_EX7, sOut7_EX7, sOut8_EX7,
    output outx_EX7, outy_EX7,
    input  result_valid, result_sad, result_x, result_y,
    input  best_valid, best_sad, best_x, best_y, busy
  );

  modport slave (
    input  sad_EX7, clear_best,
    input  sOut1_EX7, sOut2_EX7, sOut3_EX7, sOut4_EX7,
    input  sOut5_EX7, sOut6_EX7, sOut7_EX7, sOut8_EX7,
    input  outx_EX7, outy_EX7,
    output result_valid, result_sad, result_x, result_y,
    output best_valid, best_sad, best_x, best_y, busy
  );
endinterface

// File: rtl/sad_min_reduce.sv
// Three-stage min-reduction tree over eight SAD candidates, plus a running
// best-match register that persists across SAD instructions until cleared.
module sad_min_reduce #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COORD_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  sad_min_reduce_if.slave  sad
);

  logic [DATA_W-1:0]  cand [8];
  logic [DATA_W-1:0]  p1_sad [4];
  logic [2:0]         p1_idx [4];
  logic [DATA_W-1:0]  p2_sad [2];
  logic [2:0]         p2_idx [2];
  logic [DATA_W-1:0]  p3_sad;
  logic [2:0]         p3_idx;

  logic               s1_v, s2_v, s3_v;
  logic [DATA_W-1:0]  s1_sad [4];
  logic [2:0]         s1_idx [4];
  logic [DATA_W-1:0]  s2_sad [2];
  logic [2:0]         s2_idx [2];
  logic [COORD_W-1:0] s1_x, s1_y, s2_x, s2_y;
  logic [DATA_W-1:0]  s3_sad;
  logic [COORD_W-1:0] s3_x, s3_y;

  logic               bst_v;
  logic [DATA_W-1:0]  bst_sad;
  logic [COORD_W-1:0] bst_x, bst_y;

  always_comb begin
    cand[0] = sad.sOut1_EX7;
    cand[1] = sad.sOut2_EX7;
    cand[2] = sad.sOut3_EX7;
    cand[3] = sad.sOut4_EX7;
    cand[4] = sad.sOut5_EX7;
    cand[5] = sad.sOut6_EX7;
    cand[6] = sad.sOut7_EX7;
    cand[7] = sad.sOut8_EX7;
  end

  // The right-hand operand only wins on strictly-less, so ties keep the lower index.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (cand[2*i+1] < cand[2*i]) begin
        p1_sad[i] = cand[2*i+1];
        p1_idx[i] = 3'(2*i+1);
      end else begin
        p1_sad[i] = cand[2*i];
        p1_idx[i] = 3'(2*i);
      end
    end
    for (int unsigned i = 0; i < 2; i++) begin
      if (s1_sad[2*i+1] < s1_sad[2*i]) begin
        p2_sad[i] = s1_sad[2*i+1];
        p2_idx[i] = s1_idx[2*i+1];
      end else begin
        p2_sad[i] = s1_sad[2*i];
        p2_idx[i] = s1_idx[2*i];
      end
    end
    if (s2_sad[1] < s2_sad[0]) begin
      p3_sad = s2_sad[1];
      p3_idx = s2_idx[1];
    end else begin
      p3_sad = s2_sad[0];
      p3_idx = s2_idx[0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s3_v   <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
      s2_x   <= '0;
      s2_y   <= '0;
      s3_sad <= '0;
      s3_x   <= '0;
      s3_y   <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        s1_sad[i] <= '0;
        s1_idx[i] <= '0;
      end
      for (int unsigned i = 0; i < 2; i++) begin
        s2_sad[i] <= '0;
        s2_idx[i] <= '0;
      end
    end else begin
      s1_v <= sad.sad_EX7;
      s2_v <= s1_v;
      s3_v <= s2_v;
      if (sad.sad_EX7) begin
        s1_sad <= p1_sad;
        s1_idx <= p1_idx;
        s1_x   <= sad.outx_EX7;
        s1_y   <= sad.outy_EX7;
      end
      if (s1_v) begin
        s2_sad <= p2_sad;
        s2_idx <= p2_idx;
        s2_x   <= s1_x;
        s2_y   <= s1_y;
      end
      if (s2_v) begin
        s3_sad <= p3_sad;
        s3_x   <= s2_x + COORD_W'(p3_idx);
        s3_y   <= s2_y;
      end
    end
  end

  // A clear coinciding with a result behaves as clear-then-load, so the result always lands.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bst_v   <= 1'b0;
      bst_sad <= '1;
      bst_x   <= '0;
      bst_y   <= '0;
    end else if (s3_v && (sad.clear_best || !bst_v || (s3_sad < bst_sad))) begin
      bst_v   <= 1'b1;
      bst_sad <= s3_sad;
      bst_x   <= s3_x;
      bst_y   <= s3_y;
    end else if (sad.clear_best) begin
      bst_v   <= 1'b0;
      bst_sad <= '1;
      bst_x   <= '0;
      bst_y   <= '0;
    end
  end

  assign sad.result_valid = s3_v;
  assign sad.result_sad   = s3_sad;
  assign sad.result_x     = s3_x;
  assign sad.result_y     = s3_y;
  assign sad.best_valid   = bst_v;
  assign sad.best_sad     = bst_sad;
  assign sad.best_x       = bst_x;
  assign sad.best_y       = bst_y;
  assign sad.busy         = s1_v | s2_v | s3_v;

endmodule

// File: tb/tb_sad_min_reduce.sv
// Self-checking bench for sad_min_reduce: vector table plus hand-built
// sequences for latency, back-to-back, clear and reset corner cases.
module tb_sad_min_reduce;

  logic Clk;
  logic Reset;

  sad_min_reduce_if #(.DATA_W(32), .COORD_W(32)) bus ();

  sad_min_reduce #(.DATA_W(32), .COORD_W(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .sad   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0][31:0] c;
    logic [31:0] x, y, es, ex, ey;
  } vec_t;

  typedef struct packed {
    logic [31:0] s, x, y;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [31:0] c1, c2, c3, c4, c5, c6, c7, c8,
                              input logic [31:0] x, y, es, ex, ey);
    vec_t v;
    v.c[0] = c1; v.c[1] = c2; v.c[2] = c3; v.c[3] = c4;
    v.c[4] = c5; v.c[5] = c6; v.c[6] = c7; v.c[7] = c8;
    v.x = x; v.y = y; v.es = es; v.ex = ex; v.ey = ey;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input vec_t v, input bit push);
    exp_t e;
    bus.sOut1_EX7 = v.c[0]; bus.sOut2_EX7 = v.c[1];
    bus.sOut3_EX7 = v.c[2]; bus.sOut4_EX7 = v.c[3];
    bus.sOut5_EX7 = v.c[4]; bus.sOut6_EX7 = v.c[5];
    bus.sOut7_EX7 = v.c[6]; bus.sOut8_EX7 = v.c[7];
    bus.outx_EX7  = v.x;
    bus.outy_EX7  = v.y;
    bus.sad_EX7   = 1'b1;
    if (push) begin
      e.s = v.es; e.x = v.ex; e.y = v.ey;
      sbq.push_back(e);
    end
  endtask

  task automatic run_group(input vec_t v);
    tick();
    issue(v, 1'b1);
    tick();
    bus.sad_EX7 = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_clear();
    tick();
    bus.clear_best = 1'b1;
    tick();
    bus.clear_best = 1'b0;
  endtask

  task automatic chk_best(input string nm, input logic v, input logic [31:0] s, x, y);
    chk({nm, "_valid"}, 64'(bus.best_valid), 64'(v));
    chk({nm, "_sad"},   64'(bus.best_sad),   64'(s));
    chk({nm, "_x"},     64'(bus.best_x),     64'(x));
    chk({nm, "_y"},     64'(bus.best_y),     64'(y));
  endtask

  // Scoreboard: every result_valid pulse must match the oldest outstanding group.
  always @(negedge Clk) begin
    if (bus.result_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got result_valid=1 sad=%0h, expected no result", bus.result_sad);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result_sad", 64'(bus.result_sad), 64'(e.s));
        chk("result_x",   64'(bus.result_x),   64'(e.x));
        chk("result_y",   64'(bus.result_y),   64'(e.y));
      end
    end
  end

  vec_t vt [9];
  vec_t g  [3];
  vec_t g99, g5, gones;

  initial begin
    vt[0] = mk(50, 40, 30, 20, 10, 60, 70, 80, 4, 9, 10, 8, 9);
    vt[1] = mk(7, 7, 7, 7, 7, 7, 7, 7, 0, 0, 7, 0, 0);
    vt[2] = mk(7, 7, 7, 7, 7, 7, 7, 7, 100, 0, 7, 100, 0);
    vt[3] = mk(9, 9, 9, 1, 9, 9, 9, 9, 32'hFFFF_FFFE, 3, 1, 1, 3);
    vt[4] = mk(8, 7, 6, 5, 4, 3, 2, 1, 10, 2, 1, 17, 2);
    vt[5] = mk(5, 3, 3, 9, 9, 9, 9, 9, 0, 0, 3, 1, 0);
    vt[6] = mk('1, '1, '1, '1, '1, '1, 32'hFFFF_FFFE, '1, 20, 4, 32'hFFFF_FFFE, 26, 4);
    vt[7] = mk(32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
               32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
               50, 6, 32'h7FFF_FFFF, 51, 6);
    vt[8] = mk(60, 61, 62, 63, 64, 65, 66, 12, 32'hFFFF_FFFC, 8, 12, 3, 8);
    g[0]  = mk(40, 40, 30, 40, 40, 40, 40, 40, 0, 5, 30, 2, 5);
    g[1]  = mk(40, 15, 40, 40, 40, 40, 40, 40, 10, 5, 15, 11, 5);
    g[2]  = mk(40, 15, 40, 40, 40, 40, 40, 40, 20, 5, 15, 21, 5);
    g99   = mk(99, 99, 99, 99, 99, 99, 99, 99, 40, 1, 99, 40, 1);
    g5    = mk(5, 5, 5, 5, 5, 5, 5, 5, 60, 1, 5, 60, 1);
    gones = mk('1, '1, '1, '1, '1, '1, '1, '1, 3, 7, '1, 3, 7);

    Reset = 1'b1;
    bus.sad_EX7 = 1'b0;
    bus.clear_best = 1'b0;
    bus.sOut1_EX7 = '0; bus.sOut2_EX7 = '0; bus.sOut3_EX7 = '0; bus.sOut4_EX7 = '0;
    bus.sOut5_EX7 = '0; bus.sOut6_EX7 = '0; bus.sOut7_EX7 = '0; bus.sOut8_EX7 = '0;
    bus.outx_EX7 = '0;
    bus.outy_EX7 = '0;
    repeat (3) tick();
    @(negedge Clk);
    chk("rst_result_valid", 64'(bus.result_valid), 64'd0);
    chk("rst_result_sad",   64'(bus.result_sad),   64'd0);
    chk("rst_busy",         64'(bus.busy),         64'd0);
    chk_best("rst_best", 1'b0, 32'hFFFF_FFFF, 0, 0);
    tick();
    Reset = 1'b0;

    // Single group: latency 3, one-cycle pulse, best visible one cycle later.
    tick();
    issue(vt[0], 1'b1);
    for (int c = 0; c <= 4; c++) begin
      @(negedge Clk);
      chk($sformatf("lat_rv_c%0d", c), 64'(bus.result_valid), 64'(c == 3));
      if (c == 4) chk_best("lat_best", 1'b1, 10, 8, 9);
      tick();
      bus.sad_EX7 = 1'b0;
    end

    // Ties: equal SAD never displaces the earlier group.
    do_clear();
    @(negedge Clk);
    chk_best("clr_best", 1'b0, 32'hFFFF_FFFF, 0, 0);
    run_group(vt[1]);
    run_group(vt[2]);
    @(negedge Clk);
    chk_best("tie_best", 1'b1, 7, 0, 0);

    // Back-to-back groups and busy profile.
    do_clear();
    tick();
    for (int c = 0; c <= 6; c++) begin
      if (c < 3) issue(g[c], 1'b1);
      else bus.sad_EX7 = 1'b0;
      @(negedge Clk);
      chk($sformatf("b2b_busy_c%0d", c), 64'(bus.busy), 64'(c >= 1 && c <= 5));
      chk($sformatf("b2b_rv_c%0d", c), 64'(bus.result_valid), 64'(c >= 3 && c <= 5));
      if (c == 6) chk_best("b2b_best", 1'b1, 15, 11, 5);
      tick();
    end

    // Full table streamed back to back.
    for (int i = 0; i < 9; i++) begin
      issue(vt[i], 1'b1);
      tick();
    end
    bus.sad_EX7 = 1'b0;
    repeat (5) tick();

    // Clear coincident with an update edge: the new result still lands.
    do_clear();
    run_group(g5);
    @(negedge Clk);
    chk_best("pre_co_best", 1'b1, 5, 60, 1);
    tick();
    for (int c = 0; c <= 4; c++) begin
      if (c == 0) issue(g99, 1'b1);
      else bus.sad_EX7 = 1'b0;
      bus.clear_best = (c == 3);
      @(negedge Clk);
      if (c == 4) chk_best("co_best", 1'b1, 99, 40, 1);
      tick();
    end
    bus.clear_best = 1'b0;
    do_clear();
    @(negedge Clk);
    chk_best("clr2_best", 1'b0, 32'hFFFF_FFFF, 0, 0);

    // All-ones candidate still loads into an empty best.
    run_group(gones);
    @(negedge Clk);
    chk_best("ones_best", 1'b1, 32'hFFFF_FFFF, 3, 7);

    // Reset mid-flight discards the group.
    tick();
    issue(vt[0], 1'b0);
    @(negedge Clk);
    tick();
    bus.sad_EX7 = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    chk("mrst_busy_c1", 64'(bus.busy), 64'd1);
    tick();
    Reset = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge Clk);
      chk($sformatf("mrst_busy_c%0d", c), 64'(bus.busy), 64'd0);
      chk($sformatf("mrst_rv_c%0d", c), 64'(bus.result_valid), 64'd0);
      chk($sformatf("mrst_bv_c%0d", c), 64'(bus.best_valid), 64'd0);
      tick();
    end

    repeat (3) tick();
    chk("drain_outstanding", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
